// File: rtl/alu.sv
// Registered single-cycle ALU: one result per accepted operand set, one clock
// of latency, with a flag for carry, borrow, multiply overflow or divide-by-zero.
module alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  output logic             out_valid
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_DIV  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_NAND = 3'b111
  } op_t;

  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  // Arithmetic helpers are widened so carry and the upper product half survive.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  end

  // Next-result selection; an unknown select falls through to a zero result.
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    case (alu_sel)
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
      end
      OP_SUB: begin
        res   = a - b;
        res_c = (a < b);
      end
      OP_MUL: begin
        res   = prod[WIDTH-1:0];
        res_c = |prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        if (b == '0) begin
          res   = '1;
          res_c = 1'b1;
        end else begin
          res   = a / b;
        end
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NAND: res = ~(a & b);
      default: begin
        res   = '0;
        res_c = 1'b0;
      end
    endcase
  end

  // Output register: capture on valid input, otherwise hold; reset clears all.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_out   <= '0;
      carry_out <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        alu_out   <= res;
        carry_out <= res_c;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expectations are queued when operands are driven
// and retired when the registered result is sampled one clock later.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  alu_sel;
  logic        in_valid;
  logic [15:0] alu_out;
  logic        carry_out;
  logic        out_valid;

  int unsigned total;
  int unsigned bad;

  typedef struct {
    logic [15:0] out;
    logic        c;
  } res_t;

  res_t sb[$];
  res_t hold;
  logic exp_v;

  alu #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .alu_sel   (alu_sel),
    .in_valid  (in_valid),
    .alu_out   (alu_out),
    .carry_out (carry_out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written from the operation definitions in integer arithmetic.
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic [2:0] s);
    res_t r;
    int unsigned t;
    r.out = 16'h0000;
    r.c   = 1'b0;
    if ($isunknown(s)) return r;
    case (s)
      3'd0: begin t = x + y; r.out = t[15:0]; r.c = (t > 32'h0000_FFFF); end
      3'd1: begin
        r.c = (x < y);
        t = r.c ? (32'h0001_0000 + x - y) : (32'(x) - 32'(y));
        r.out = t[15:0];
      end
      3'd2: begin t = x * y; r.out = t[15:0]; r.c = (t >= 32'h0001_0000); end
      3'd3: begin
        if (y == 16'h0000) begin r.out = 16'hFFFF; r.c = 1'b1; end
        else begin t = x / y; r.out = t[15:0]; end
      end
      3'd4: r.out = x & y;
      3'd5: r.out = x | y;
      3'd6: r.out = x ^ y;
      default: r.out = ~(x & y);
    endcase
    return r;
  endfunction

  // Drives one cycle of stimulus and prepares the expectation for the sample after the edge.
  task automatic step(input logic [15:0] ia, input logic [15:0] ib, input logic [2:0] isel,
                      input logic iv, input logic irst);
    res_t e;
    a = ia; b = ib; alu_sel = isel; in_valid = iv; rst_n = irst;
    if (irst && iv) sb.push_back(model(a, b, alu_sel));
    @(posedge clk);
    #1;
    if (!irst) begin
      sb.delete();
      hold.out = 16'h0000;
      hold.c   = 1'b0;
      exp_v    = 1'b0;
    end else if (sb.size() != 0) begin
      e = sb.pop_front();
      hold  = e;
      exp_v = 1'b1;
    end else begin
      exp_v = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(16'hFFFF, 16'h0001, 3'b000, 1'b1, 1'b0);
      total += 3;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      if (alu_out !== 16'h0000) begin bad++; $display("FAIL reset_out got=%h want=0000", alu_out); end
      if (carry_out !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b want=0", carry_out); end
    end
  endtask

  task automatic test_vectors();
    logic [15:0] va[15];
    logic [15:0] vb[15];
    logic [2:0]  vs[15];
    logic [15:0] want_out[15];
    logic        want_c[15];
    va = '{16'h0001,16'hFFFF,16'h0002,16'h0001,16'hFFFF,16'h0002,16'h0006,16'h1234,
           16'hAAAA,16'hAAAA,16'hAAAA,16'hAAAA,16'h0100,16'hFFFF,16'h0007};
    vb = '{16'h0001,16'h0001,16'h0001,16'h0002,16'h0001,16'h0003,16'h0003,16'h0000,
           16'h5555,16'h5555,16'h5555,16'h5555,16'h0100,16'hFFFF,16'h0002};
    vs = '{3'd0,3'd0,3'd1,3'd1,3'd1,3'd2,3'd3,3'd3,3'd4,3'd5,3'd6,3'd7,3'd2,3'd0,3'd3};
    want_out = '{16'h0002,16'h0000,16'h0001,16'hFFFF,16'hFFFE,16'h0006,16'h0002,16'hFFFF,
                 16'h0000,16'hFFFF,16'hFFFF,16'hFFFF,16'h0000,16'hFFFE,16'h0003};
    want_c = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
    for (int i = 0; i < 15; i++) begin
      step(va[i], vb[i], vs[i], 1'b1, 1'b1);
      total += 3;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL vec%0d_valid got=%b want=1", i, out_valid); end
      if (alu_out !== want_out[i]) begin bad++; $display("FAIL vec%0d_out got=%h want=%h", i, alu_out, want_out[i]); end
      if (carry_out !== want_c[i]) begin bad++; $display("FAIL vec%0d_carry got=%b want=%b", i, carry_out, want_c[i]); end
    end
  endtask

  task automatic test_unknown_sel();
    step(16'h1234, 16'h5678, 3'bxxx, 1'b1, 1'b1);
    total += 3;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL unk_valid got=%b want=1", out_valid); end
    if (alu_out !== hold.out) begin bad++; $display("FAIL unk_out got=%h want=%h", alu_out, hold.out); end
    if (carry_out !== hold.c) begin bad++; $display("FAIL unk_carry got=%b want=%b", carry_out, hold.c); end
  endtask

  task automatic test_gap_hold();
    step(16'h00F0, 16'h000F, 3'd5, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(16'h0001, 16'h0000, 3'd3, 1'b0, 1'b1);
      total += 3;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL gap%0d_valid got=%b want=0", i, out_valid); end
      if (alu_out !== 16'h00FF) begin bad++; $display("FAIL gap%0d_out got=%h want=00ff", i, alu_out); end
      if (carry_out !== 1'b0) begin bad++; $display("FAIL gap%0d_carry got=%b want=0", i, carry_out); end
    end
  endtask

  task automatic test_reset_mid();
    step(16'hFFFF, 16'hFFFF, 3'd2, 1'b1, 1'b1);
    step(16'hFFFF, 16'h0001, 3'd0, 1'b1, 1'b0);
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", out_valid); end
    if (alu_out !== 16'h0000) begin bad++; $display("FAIL mid_rst_out got=%h want=0000", alu_out); end
    if (carry_out !== 1'b0) begin bad++; $display("FAIL mid_rst_carry got=%b want=0", carry_out); end
    step(16'hFFFF, 16'h0001, 3'd0, 1'b0, 1'b1);
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL post_rst_valid got=%b want=0", out_valid); end
    if (alu_out !== 16'h0000) begin bad++; $display("FAIL post_rst_out got=%h want=0000", alu_out); end
    step(16'h0003, 16'h0004, 3'd2, 1'b1, 1'b1);
    total += 3;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b want=1", out_valid); end
    if (alu_out !== 16'h000C) begin bad++; $display("FAIL first_out got=%h want=000c", alu_out); end
    if (carry_out !== 1'b0) begin bad++; $display("FAIL first_carry got=%b want=0", carry_out); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ra, rb;
    logic [2:0]  rs;
    logic        rv;
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = (i % 9 == 0) ? 16'h0000 : 16'($urandom);
      rs = 3'($urandom_range(0, 7));
      rv = (i < 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
      step(ra, rb, rs, rv, 1'b1);
      total += 3;
      if (out_valid !== exp_v) begin bad++; $display("FAIL b2b%0d_valid got=%b want=%b", i, out_valid, exp_v); end
      if (alu_out !== hold.out) begin bad++; $display("FAIL b2b%0d_out got=%h want=%h", i, alu_out, hold.out); end
      if (carry_out !== hold.c) begin bad++; $display("FAIL b2b%0d_carry got=%b want=%b", i, carry_out, hold.c); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0; b = '0; alu_sel = '0;
    hold.out = 16'h0000;
    hold.c   = 1'b0;
    exp_v    = 1'b0;
    @(negedge clk);
    test_reset();
    test_vectors();
    test_unknown_sel();
    test_gap_hold();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
